aes_dec_core: RTL and testbench

AES_DEC_CORE -- requirements
Module: aes_dec_core

---
 rtl/aes_dec_core.sv | 257 +++++++++++++++++++++++++
 tb/tb_aes_dec_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_core.sv
// AES-128 decryption core: iterative inverse cipher with a cached round-key schedule.
package aes_dec_pkg;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = a;
        res = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
                gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
                gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
                gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
    endfunction

endpackage

// Forward AES-128 key schedule, one round key per enabled clock.
// Latency: key_out = rk0 one edge after load, then rk(n+1) per edge with next=1.
// Backpressure: none; holds key_out while load and next are both low.
module key_expander (
    input  logic         clk,
    input  logic         load,
    input  logic         next,
    input  logic [127:0] key_in,
    output logic [127:0] key_out
);
    import aes_dec_pkg::*;

    logic [7:0]  rcon;
    logic [31:0] temp;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] n3;

    // RotWord then SubWord of the last word, with rcon folded into the leading byte.
    always_comb begin
        temp = {sbox(key_out[23:16]) ^ rcon, sbox(key_out[15:8]),
                sbox(key_out[7:0]), sbox(key_out[31:24])};
        n0   = key_out[127:96] ^ temp;
        n1   = key_out[95:64]  ^ n0;
        n2   = key_out[63:32]  ^ n1;
        n3   = key_out[31:0]   ^ n2;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            key_out <= key_in;
            rcon    <= 8'h01;
        end else if (next) begin
            key_out <= {n0, n1, n2, n3};
            rcon    <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end
endmodule

// One inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
// Latency: 1 cycle, result registered on the edge where en=1.
// Backpressure: none; state_out holds while en is low.
module aes_inv_round (
    input  logic         clk,
    input  logic         en,
    input  logic         skip_invmixcols,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);
    import aes_dec_pkg::*;

    logic [127:0] ark;
    logic [127:0] mixed;

    // Byte b = 4*col + row; row r of the output takes column (col - r) mod 4 of the input.
    always_comb begin
        ark = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[127 - 8*(4*c + r) -: 8] =
                    inv_sbox(state_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8])
                    ^ round_key[127 - 8*(4*c + r) -: 8];
            end
        end
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
        end
    end

    always_ff @(posedge clk) begin
        if (en) state_out <= skip_invmixcols ? ark : mixed;
    end
endmodule

// AES-128 decryption top: 32 cycles on a key-cache miss, 21 on a hit.
// Latency: valid pulses 32 (miss) / 21 (hit) edges after start is sampled in IDLE.
// Backpressure: start is ignored while busy; inputs are captured only at acceptance.
module aes_dec_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] block_in,
    output logic         busy,
    output logic         valid,
    output logic [127:0] block_out
);
    typedef enum logic [2:0] {IDLE, KEXP, ADDKEY, EXEC, LATCH} state_t;

    state_t       state;
    logic [3:0]   cnt;
    logic [3:0]   rnd;
    logic [127:0] st;
    logic [127:0] cached_key;
    logic         cache_vld;
    logic [127:0] rk [0:10];
    logic         hit;
    logic         k_load;
    logic         k_next;
    logic [127:0] k_out;
    logic         en;
    logic         skip_invmixcols;
    logic [127:0] round_key;
    logic [127:0] state_out;

    assign hit             = cache_vld && (key == cached_key);
    assign k_load          = rst_n && (state == IDLE) && start && !hit;
    assign k_next          = (state == KEXP) && (cnt < 4'd10);
    assign round_key       = rk[rnd];
    assign skip_invmixcols = (rnd == 4'd0);

    key_expander u_kexp (
        .clk     (clk),
        .load    (k_load),
        .next    (k_next),
        .key_in  (key),
        .key_out (k_out)
    );

    aes_inv_round u_round (
        .clk             (clk),
        .en              (en),
        .skip_invmixcols (skip_invmixcols),
        .state_in        (st),
        .round_key       (round_key),
        .state_out       (state_out)
    );

    // The key store is only trusted while cache_vld is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (k_load) cached_key <= key;
        if (state == KEXP) rk[cnt] <= k_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid     <= 1'b0;
            block_out <= '0;
            cache_vld <= 1'b0;
            cnt       <= 4'd0;
            rnd       <= 4'd0;
            en        <= 1'b0;
            st        <= '0;
        end else begin
            valid <= 1'b0;
            en    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        st   <= block_in;
                        busy <= 1'b1;
                        if (hit) begin
                            state <= ADDKEY;
                        end else begin
                            cache_vld <= 1'b0;
                            cnt       <= 4'd0;
                            state     <= KEXP;
                        end
                    end
                end
                KEXP: begin
                    if (cnt == 4'd10) begin
                        cnt       <= 4'd0;
                        cache_vld <= 1'b1;
                        state     <= ADDKEY;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ADDKEY: begin
                    st    <= st ^ rk[10];
                    rnd   <= 4'd9;
                    en    <= 1'b1;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= LATCH;
                end
                LATCH: begin
                    st <= state_out;
                    if (rnd == 4'd0) begin
                        block_out <= state_out;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        rnd   <= rnd - 4'd1;
                        en    <= 1'b1;
                        state <= EXEC;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    cnt   <= 4'd0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_dec_core.sv
// Bench for aes_dec_core: transaction-level AES model plus FIPS-197 literal vectors.
module tb_aes_dec_core;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic [127:0] block_in;
    logic         busy;
    logic         valid;
    logic [127:0] block_out;

    int n_checks = 0;
    int n_fail   = 0;
    int kload_cnt = 0;
    bit cmp_en = 1'b0;

    aes_dec_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .block_in  (block_in),
        .busy      (busy),
        .valid     (valid),
        .block_out (block_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (log/antilog GF arithmetic) ----------------
    logic [7:0] exp_t [256];
    logic [7:0] log_t [256];
    logic [7:0] sb    [256];
    logic [7:0] isb   [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
    endfunction

    task automatic build_tables();
        logic [7:0] v;
        logic [7:0] inv;
        logic [7:0] s;
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = v;
            log_t[v] = 8'(i);
            v = v ^ xt(v);
        end
        exp_t[255] = 8'h01;
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : exp_t[(255 - int'(log_t[x])) % 255];
            s = 8'h63;
            for (int i = 0; i < 8; i++)
                s[i] = s[i] ^ inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] ct);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        int row;
        int col;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = ct[127 - 8*b -: 8] ^ w[40 + b/4][31 - 8*(b%4) -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int b = 0; b < 16; b++) begin
                row = b % 4;
                col = b / 4;
                t[b] = isb[s[row + 4*((col - row + 4) % 4)]] ^ w[4*r + col][31 - 8*row -: 8];
            end
            for (int b = 0; b < 16; b++) begin
                row = b % 4;
                col = b / 4;
                if (r > 0)
                    s[b] = gm(8'h0e, t[4*col + row])           ^ gm(8'h0b, t[4*col + (row + 1) % 4])
                         ^ gm(8'h0d, t[4*col + (row + 2) % 4]) ^ gm(8'h09, t[4*col + (row + 3) % 4]);
                else
                    s[b] = t[b];
            end
        end
        for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
        return res;
    endfunction

    // Transaction model: one request in flight, completion a fixed number of edges later.
    int           edge_n = 0;
    int           m_due  = 0;
    bit           m_busy = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_hit;
    bit           m_cache_ok = 1'b0;
    logic [127:0] m_cache_key = '0;
    logic [127:0] m_result = '0;
    logic [127:0] m_out = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy     = 1'b0;
            m_valid    = 1'b0;
            m_out      = '0;
            m_cache_ok = 1'b0;
        end else begin
            edge_n++;
            m_valid = 1'b0;
            if (m_busy) begin
                if (edge_n == m_due) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b1;
                    m_out   = m_result;
                end
            end else if (start) begin
                m_hit       = m_cache_ok && (key == m_cache_key);
                m_due       = edge_n + (m_hit ? 21 : 32);
                m_result    = model_decrypt(key, block_in);
                m_cache_key = key;
                m_cache_ok  = 1'b1;
                m_busy      = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid", {127'b0, valid}, {127'b0, m_valid});
            check("busy", {127'b0, busy}, {127'b0, m_busy});
            check("block_out", block_out, m_out);
        end
    end

    always @(negedge clk) begin
        #1;
        if (dut.k_load) kload_cnt++;
    end

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at a negedge; returns at the negedge of the valid cycle.
    task automatic run_op(input logic [127:0] k, input logic [127:0] c, input bit noise,
                          input int exp_lat, input logic [127:0] exp_pt, input string name);
        int lat;
        int k0;
        key      = k;
        block_in = c;
        start    = 1'b1;
        k0       = kload_cnt;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        do begin
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                key      = rand128();
                block_in = rand128();
            end
            @(negedge clk);
            lat++;
        end while (!valid && lat < 100);
        start = 1'b0;
        if (lat >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no valid within %0d cycles", name, lat);
        end else if (exp_lat > 0) begin
            check({name, "_latency"}, 128'(lat), 128'(exp_lat));
            check({name, "_plaintext"}, block_out, exp_pt);
            check({name, "_kload_pulses"}, 128'(kload_cnt - k0), (exp_lat == 32) ? 128'd1 : 128'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [127:0] key_pool [3];
    logic [127:0] rk;
    int           gap;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        key      = '0;
        block_in = '0;
        build_tables();
        check("model_sbox_00", {120'b0, sb[0]}, 128'h63);
        check("model_sbox_53", {120'b0, sb[8'h53]}, 128'hed);
        check("model_invsbox_63", {120'b0, isb[8'h63]}, 128'h00);
        check("model_fips_c1", model_decrypt(KEY1, CT1), PT1);
        check("model_fips_b", model_decrypt(KEY2, CT2), PT2);

        repeat (3) @(negedge clk);
        check("reset_busy", {127'b0, busy}, 128'd0);
        check("reset_valid", {127'b0, valid}, 128'd0);
        check("reset_block_out", block_out, 128'd0);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        run_op(KEY1, CT1, 1'b0, 32, PT1, "miss");
        run_op(KEY1, CT1, 1'b0, 21, PT1, "hit_on_valid");
        run_op(KEY2, CT2, 1'b0, 32, PT2, "key_change");
        repeat (2) @(negedge clk);
        run_op(KEY1, CT1, 1'b1, 32, PT1, "busy_noise");
        repeat (3) @(negedge clk);

        // Hit operation aborted by an asynchronous reset after its 15th edge.
        key      = KEY1;
        block_in = CT1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        @(posedge clk);
        #2;
        check("abort_busy_before", {127'b0, busy}, 128'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {127'b0, busy}, 128'd0);
        check("abort_valid", {127'b0, valid}, 128'd0);
        check("abort_block_out", block_out, 128'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op(KEY1, CT1, 1'b0, 32, PT1, "after_reset");

        for (int i = 0; i < 3; i++) key_pool[i] = rand128();
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            rk = ($urandom_range(0, 4) == 0) ? rand128() : key_pool[$urandom_range(0, 2)];
            run_op(rk, rand128(), 1'($urandom_range(0, 1)), 0, '0, "random");
        end
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
